// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: lamp encoding, phase codes
// and the lamp decode used by the controller's registered outputs.
package traffic_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10,
    RED    = 2'b11
  } light_t;

  // Phase codes double as the debug phase output.
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_A    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALLRED_B    = 3'd5,
    FLASH       = 3'd6
  } tl_state_t;

  // Main-road lamp for a given phase; in FLASH it blinks yellow.
  function automatic light_t main_lamp(input tl_state_t s, input logic blink);
    case (s)
      MAIN_GREEN:  return GREEN;
      MAIN_YELLOW: return YELLOW;
      FLASH:       return blink ? YELLOW : OFF;
      default:     return RED;
    endcase
  endfunction

  // Side-road lamp for a given phase; in FLASH it blinks red.
  function automatic light_t side_lamp(input tl_state_t s, input logic blink);
    case (s)
      SIDE_GREEN:  return GREEN;
      SIDE_YELLOW: return YELLOW;
      FLASH:       return blink ? RED : OFF;
      default:     return RED;
    endcase
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable down-counter used to time each phase. Loading takes priority;
// otherwise the count decrements and rests at zero. expired is a pure
// decode of the count so it is valid in the same cycle the count hits zero.
module tl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             expired
);

  // Load on request, else count down and saturate at zero.
  always_ff @(posedge clk) begin
    if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - CNT_W'(1);
    end
  end

  assign expired = (value == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: main road rests in green, side road is
// served on demand (vehicle or pedestrian), with yellow and all-red
// clearance between roads and a maintenance flash mode.
// The next phase is decided combinationally; the state, demand latches and
// all lamp outputs are registered from that decision, so outputs change on
// the same edge as the phase with no extra latency.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int MAIN_GREEN_CYC = 20,
  parameter int SIDE_GREEN_CYC = 10,
  parameter int YELLOW_CYC     = 4,
  parameter int ALLRED_CYC     = 2,
  parameter int FLASH_CYC      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  tl_state_t        state;
  tl_state_t        nxt;
  logic             side_pend;
  logic             ped_pend;
  logic             blink;
  logic             nxt_blink;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic [CNT_W-1:0] timer_value;
  logic             expired;

  // Timer reload value for the phase being entered.
  function automatic logic [CNT_W-1:0] load_for(input tl_state_t s);
    case (s)
      MAIN_GREEN:               return CNT_W'(MAIN_GREEN_CYC - 1);
      MAIN_YELLOW, SIDE_YELLOW: return CNT_W'(YELLOW_CYC - 1);
      SIDE_GREEN:               return CNT_W'(SIDE_GREEN_CYC - 1);
      FLASH:                    return CNT_W'(FLASH_CYC - 1);
      default:                  return CNT_W'(ALLRED_CYC - 1);
    endcase
  endfunction

  tl_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .load    (timer_load),
    .load_val(timer_val),
    .value   (timer_value),
    .expired (expired)
  );

  // Next-phase decision, timer reload and blink update.
  always_comb begin
    nxt        = state;
    nxt_blink  = blink;
    timer_load = 1'b0;
    timer_val  = '0;

    if (flash_en) begin
      nxt = FLASH;
    end else begin
      case (state)
        MAIN_GREEN:  if (expired && (side_pend || ped_pend)) nxt = MAIN_YELLOW;
        MAIN_YELLOW: if (expired) nxt = ALLRED_A;
        ALLRED_A:    if (expired) nxt = SIDE_GREEN;
        SIDE_GREEN:  if (expired) nxt = SIDE_YELLOW;
        SIDE_YELLOW: if (expired) nxt = ALLRED_B;
        ALLRED_B:    if (expired) nxt = MAIN_GREEN;
        FLASH:       nxt = ALLRED_B;
        default:     nxt = ALLRED_B;
      endcase
    end

    if (nxt != state) begin
      // Every phase entry restarts the timer; flash always starts lit.
      timer_load = 1'b1;
      timer_val  = load_for(nxt);
      if (nxt == FLASH) nxt_blink = 1'b1;
    end else if (state == FLASH && expired) begin
      // Staying in flash: each expiry flips the lamps and restarts the half-period.
      timer_load = 1'b1;
      timer_val  = load_for(FLASH);
      nxt_blink  = ~blink;
    end

    if (reset) begin
      timer_load = 1'b1;
      timer_val  = load_for(ALLRED_B);
    end
  end

  // Phase register, demand latches, walk and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ALLRED_B;
      side_pend  <= 1'b0;
      ped_pend   <= 1'b0;
      blink      <= 1'b0;
      walk       <= 1'b0;
      main_light <= RED;
      side_light <= RED;
      phase      <= ALLRED_B;
    end else begin
      state <= nxt;
      blink <= nxt_blink;

      // Demand is discarded in flash and when the side road is being served;
      // a request coinciding with that service edge is covered by it.
      if (state == FLASH || nxt == FLASH ||
          (nxt == SIDE_GREEN && state != SIDE_GREEN)) begin
        side_pend <= 1'b0;
        ped_pend  <= 1'b0;
      end else begin
        side_pend <= side_pend | side_req;
        ped_pend  <= ped_pend | ped_req;
      end

      // Walk is granted for the whole side green only if a pedestrian asked.
      if (nxt == SIDE_GREEN && state != SIDE_GREEN) begin
        walk <= ped_pend;
      end else if (nxt != SIDE_GREEN) begin
        walk <= 1'b0;
      end

      main_light <= main_lamp(nxt, nxt_blink);
      side_light <= side_lamp(nxt, nxt_blink);
      phase      <= nxt;
    end
  end

  // The timer can never hold more than the current phase's reload value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (timer_value <= load_for(state));
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with short phase durations.
// Outputs are packed as {main_light, side_light, walk, phase} and compared
// once per cycle against an expected queue of hand-derived vectors.
module tb_traffic_light_ctrl;

  logic       clk;
  logic       reset;
  logic       side_req;
  logic       ped_req;
  logic       flash_en;
  logic [1:0] main_light;
  logic [1:0] side_light;
  logic       walk;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs;
  assign obs = {main_light, side_light, walk, phase};

  // {main, side, walk, phase}
  localparam logic [7:0] V_MG     = 8'b01_11_0_000;
  localparam logic [7:0] V_MY     = 8'b10_11_0_001;
  localparam logic [7:0] V_ARA    = 8'b11_11_0_010;
  localparam logic [7:0] V_SG     = 8'b11_01_0_011;
  localparam logic [7:0] V_SGW    = 8'b11_01_1_011;
  localparam logic [7:0] V_SY     = 8'b11_10_0_100;
  localparam logic [7:0] V_ARB    = 8'b11_11_0_101;
  localparam logic [7:0] V_FL_ON  = 8'b10_11_0_110;
  localparam logic [7:0] V_FL_OFF = 8'b00_00_0_110;

  traffic_light_ctrl #(
    .CNT_W         (8),
    .MAIN_GREEN_CYC(4),
    .SIDE_GREEN_CYC(3),
    .YELLOW_CYC    (2),
    .ALLRED_CYC    (1),
    .FLASH_CYC     (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .side_req  (side_req),
    .ped_req   (ped_req),
    .flash_en  (flash_en),
    .main_light(main_light),
    .side_light(side_light),
    .walk      (walk),
    .phase     (phase)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (main,side,walk,phase)", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // One cycle per queued vector.
  task automatic drain(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  initial begin
    reset    = 1'b1;
    side_req = 1'b0;
    ped_req  = 1'b0;
    flash_en = 1'b0;

    // Reset for two cycles, then idle: main green rests indefinitely.
    tick(); tick();
    check("reset_state", obs, V_ARB);
    reset = 1'b0;
    push(V_MG, 30);
    drain("idle_green");

    // Side vehicle request after the minimum green has long elapsed.
    side_req = 1'b1; tick(); side_req = 1'b0;
    check("side_latch", obs, V_MG);
    push(V_MY, 2); push(V_ARA, 1); push(V_SG, 3); push(V_SY, 2); push(V_ARB, 1);
    push(V_MG, 1);
    drain("side_cycle");

    // Pedestrian request on the first main green cycle: full minimum green,
    // then walk during all of side green.
    ped_req = 1'b1; tick(); ped_req = 1'b0;
    check("ped_latch", obs, V_MG);
    push(V_MG, 2); push(V_MY, 2); push(V_ARA, 1); push(V_SGW, 3); push(V_SY, 2);
    push(V_ARB, 1); push(V_MG, 6);
    drain("ped_cycle");

    // Side request while side green is running forces another service.
    side_req = 1'b1; tick(); side_req = 1'b0;
    check("side_latch2", obs, V_MG);
    push(V_MY, 2); push(V_ARA, 1); push(V_SG, 1);
    drain("to_side");
    side_req = 1'b1; tick(); side_req = 1'b0;
    check("req_in_side_green", obs, V_SG);
    push(V_SG, 1); push(V_SY, 2); push(V_ARB, 1); push(V_MG, 4); push(V_MY, 2);
    push(V_ARA, 1); push(V_SG, 3); push(V_SY, 2); push(V_ARB, 1); push(V_MG, 6);
    drain("forced_recycle");

    // Flash entered from side green; pedestrian request held throughout.
    side_req = 1'b1; tick(); side_req = 1'b0;
    check("side_latch3", obs, V_MG);
    push(V_MY, 2); push(V_ARA, 1); push(V_SG, 1);
    drain("to_side2");
    flash_en = 1'b1; ped_req = 1'b1; tick();
    check("flash_entry", obs, V_FL_ON);
    push(V_FL_ON, 1); push(V_FL_OFF, 2); push(V_FL_ON, 2); push(V_FL_OFF, 2);
    drain("flash_blink");
    flash_en = 1'b0; ped_req = 1'b0; tick();
    check("flash_exit", obs, V_ARB);
    push(V_MG, 8);
    drain("post_flash_no_service");

    // Reset in the second yellow cycle with side demand pending.
    side_req = 1'b1; tick(); side_req = 1'b0;
    check("side_latch4", obs, V_MG);
    push(V_MY, 2);
    drain("to_yellow");
    reset = 1'b1; tick();
    check("reset_mid", obs, V_ARB);
    tick();
    check("reset_hold", obs, V_ARB);
    reset = 1'b0;
    push(V_MG, 8);
    drain("post_reset_green");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
